// File: rtl/scan_test_sequencer.sv
// Scan test sequencer: streams patterns into a full-scan core, pulses capture,
// unloads responses (overlapped with the next load) and tallies mismatches.
module scan_test_sequencer #(
    parameter int CHAIN_LEN = 4,
    parameter int NUM_PI    = 2,
    parameter int NUM_PO    = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic                 pat_last,
    input  logic [CHAIN_LEN-1:0] pat_si,
    input  logic [NUM_PI-1:0]    pat_pi,
    input  logic [NUM_PO-1:0]    pat_xpo,
    input  logic [CHAIN_LEN-1:0] pat_xso,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic [NUM_PI-1:0]    pi,
    input  logic                 scan_out,
    input  logic [NUM_PO-1:0]    po,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     pat_count,
    output logic [CNT_W-1:0]     fail_count
);

    localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CHAIN_LEN-1:0]   si_q, si_d;
    logic [CHAIN_LEN-1:0]   so_q, so_d;
    logic [CHAIN_LEN-1:0]   xso_q, xso_d;
    logic [CHAIN_LEN-1:0]   xso_prev_q, xso_prev_d;
    logic [NUM_PI-1:0]      pi_q, pi_d;
    logic [NUM_PO-1:0]      xpo_q, xpo_d;
    logic                   last_q, last_d;
    logic                   have_resp_q, have_resp_d;
    logic                   po_pend_q, po_pend_d;
    logic                   fail_q, fail_d;
    logic [CNT_W-1:0]       pat_count_q, pat_count_d;
    logic [CNT_W-1:0]       fail_count_q, fail_count_d;
    logic [CHAIN_LEN-1:0]   so_shift;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Response word as it will stand after this edge's shift.
    assign so_shift = CHAIN_LEN'({so_q, scan_out});

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        si_d         = si_q;
        so_d         = so_q;
        xso_d        = xso_q;
        xso_prev_d   = xso_prev_q;
        pi_d         = pi_q;
        xpo_d        = xpo_q;
        last_d       = last_q;
        have_resp_d  = have_resp_q;
        po_pend_d    = po_pend_q;
        fail_d       = fail_q;
        pat_count_d  = pat_count_q;
        fail_count_d = fail_count_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fail_d       = 1'b0;
                        pat_count_d  = '0;
                        fail_count_d = '0;
                        have_resp_d  = 1'b0;
                        po_pend_d    = 1'b0;
                        state_d      = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pat_valid) begin
                        si_d      = pat_si;
                        pi_d      = pat_pi;
                        xpo_d     = pat_xpo;
                        xso_d     = pat_xso;
                        last_d    = pat_last;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end
                end
                S_SHIFT, S_UNLOAD: begin
                    si_d      = si_q << 1;
                    so_d      = so_shift;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        // A pending PO miss and a chain miss together count once.
                        if (have_resp_q) begin
                            if ((so_shift != xso_prev_q) || po_pend_q) begin
                                fail_d       = 1'b1;
                                fail_count_d = sat_inc(fail_count_q);
                            end
                            po_pend_d = 1'b0;
                        end
                        state_d = (state_q == S_SHIFT) ? S_CAPTURE : S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if (po != xpo_q) begin
                        po_pend_d = 1'b1;
                        fail_d    = 1'b1;
                    end
                    pat_count_d = sat_inc(pat_count_q);
                    xso_prev_d  = xso_q;
                    have_resp_d = 1'b1;
                    state_d     = last_q ? S_UNLOAD : S_LOAD;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            si_q         <= '0;
            so_q         <= '0;
            xso_q        <= '0;
            xso_prev_q   <= '0;
            pi_q         <= '0;
            xpo_q        <= '0;
            last_q       <= 1'b0;
            have_resp_q  <= 1'b0;
            po_pend_q    <= 1'b0;
            fail_q       <= 1'b0;
            pat_count_q  <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            si_q         <= si_d;
            so_q         <= so_d;
            xso_q        <= xso_d;
            xso_prev_q   <= xso_prev_d;
            pi_q         <= pi_d;
            xpo_q        <= xpo_d;
            last_q       <= last_d;
            have_resp_q  <= have_resp_d;
            po_pend_q    <= po_pend_d;
            fail_q       <= fail_d;
            pat_count_q  <= pat_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    always_comb begin
        pat_ready  = (state_q == S_LOAD);
        scan_en    = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
        scan_in    = (state_q == S_SHIFT) ? si_q[CHAIN_LEN-1] : 1'b0;
        pi         = (state_q == S_CAPTURE) ? pi_q : '0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        fail       = fail_q;
        pat_count  = pat_count_q;
        fail_count = fail_count_q;
    end

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Directed bench for scan_test_sequencer with a behavioural 4-flop scan core
// and a queue of expected scan_in bits checked whenever the chain shifts.
module tb_scan_test_sequencer;

    localparam int CL  = 4;
    localparam int NPI = 2;
    localparam int NPO = 2;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst_n, start, abort, pat_valid, pat_ready, pat_last;
    logic [CL-1:0]  pat_si, pat_xso;
    logic [NPI-1:0] pat_pi, pi;
    logic [NPO-1:0] pat_xpo, po;
    logic           scan_en, scan_in, scan_out, busy, done, fail;
    logic [CW-1:0]  pat_count, fail_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic exp_si[$];
    logic [CL-1:0] chain = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_test_sequencer #(
        .CHAIN_LEN(CL), .NUM_PI(NPI), .NUM_PO(NPO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_last(pat_last),
        .pat_si(pat_si), .pat_pi(pat_pi), .pat_xpo(pat_xpo), .pat_xso(pat_xso),
        .scan_en(scan_en), .scan_in(scan_in), .pi(pi), .scan_out(scan_out),
        .po(po), .busy(busy), .done(done), .fail(fail),
        .pat_count(pat_count), .fail_count(fail_count)
    );

    // Core under test: shift chain; capture XORs the PIs into the chain.
    assign scan_out = chain[CL-1];
    assign po       = chain[NPO-1:0] ^ pi;
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[CL-2:0], scan_in};
        else         chain <= chain ^ {pi, pi};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic e;
        if (rst_n === 1'b1 && scan_en === 1'b1) begin
            e = (exp_si.size() > 0) ? exp_si.pop_front() : 1'bx;
            check("scan_in", scan_in, e);
        end
    end

    task automatic begin_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_pat(input logic [CL-1:0] si, input logic [NPI-1:0] p,
                             input logic last, input logic bad_po, input logic bad_so);
        logic [NPO-1:0] xpo;
        logic [CL-1:0]  xso;
        xpo = si[NPO-1:0] ^ p;
        xso = si ^ {p, p};
        if (bad_po) xpo[0] = ~xpo[0];
        if (bad_so) xso[0] = ~xso[0];
        pat_si = si; pat_pi = p; pat_last = last; pat_xpo = xpo; pat_xso = xso;
        pat_valid = 1'b1;
        for (int i = CL - 1; i >= 0; i--) exp_si.push_back(si[i]);
        if (last) repeat (CL) exp_si.push_back(1'b0);
    endtask

    task automatic handshake();
        int n = 0;
        while (pat_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("handshake", pat_ready, 1);
        @(posedge clk);
        #1 pat_valid = 1'b0;
    endtask

    // Returns on the negedge of the CAPTURE cycle.
    task automatic send_pat(input logic [CL-1:0] si, input logic [NPI-1:0] p,
                            input logic last, input logic bad_po, input logic bad_so);
        drive_pat(si, p, last, bad_po, bad_so);
        handshake();
        repeat (CL + 1) @(negedge clk);
        check("cap_pi", pi, p);
        check("cap_scan_en", scan_en, 0);
        check("cap_ready", pat_ready, 0);
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("done_busy", busy, 0);
        at = cyc;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, t;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
        pat_si = '0; pat_pi = '0; pat_xpo = '0; pat_xso = '0;
        repeat (2) @(negedge clk);
        check("rst_scan_en", scan_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", pat_ready, 0);
        check("rst_done", done, 0);
        check("rst_pi", pi, 0);
        check("rst_fail", fail, 0);
        check("rst_pat_count", pat_count, 0);
        check("rst_fail_count", fail_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pattern: start-to-done latency and clean result.
        c0 = cyc;
        begin_session();
        check("load_ready", pat_ready, 1);
        send_pat(4'b1011, 2'b01, 1'b1, 1'b0, 1'b0);
        wait_done(t);
        check("latency", t - c0, 11);
        check("t2_pat_count", pat_count, 1);
        check("t2_fail_count", fail_count, 0);
        check("t2_fail", fail, 0);

        // Three clean patterns with overlapped unload.
        begin_session();
        send_pat(4'b0110, 2'b10, 1'b0, 1'b0, 1'b0);
        send_pat(4'b1100, 2'b11, 1'b0, 1'b0, 1'b0);
        send_pat(4'b0011, 2'b01, 1'b1, 1'b0, 1'b0);
        wait_done(t);
        check("t3_pat_count", pat_count, 3);
        check("t3_fail_count", fail_count, 0);
        check("t3_fail", fail, 0);

        // Pattern 2 misses on both PO and chain: counted once.
        begin_session();
        send_pat(4'b1001, 2'b00, 1'b0, 1'b0, 1'b0);
        send_pat(4'b0101, 2'b10, 1'b0, 1'b1, 1'b1);
        send_pat(4'b1110, 2'b01, 1'b1, 1'b0, 1'b0);
        wait_done(t);
        check("t4_pat_count", pat_count, 3);
        check("t4_fail_count", fail_count, 1);
        check("t4_fail", fail, 1);
        repeat (3) @(negedge clk);
        check("t4_fail_hold", fail, 1);

        // Stall in LOAD, then abort.
        begin_session();
        send_pat(4'b0101, 2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_ready", pat_ready, 1);
            check("stall_scan_en", scan_en, 0);
            check("stall_count", pat_count, 1);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", pat_ready, 0);
        check("abort_count", pat_count, 1);
        check("abort_fail", fail, 0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of SHIFT.
        begin_session();
        send_pat(4'b0111, 2'b01, 1'b0, 1'b1, 1'b0);
        drive_pat(4'b1010, 2'b11, 1'b0, 1'b0, 1'b0);
        handshake();
        @(negedge clk);
        check("pre_rst_count", pat_count, 1);
        check("pre_rst_scan_en", scan_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_scan_en", scan_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", pat_ready, 0);
        check("mid_rst_count", pat_count, 0);
        check("mid_rst_fail", fail, 0);
        exp_si.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Five failing patterns saturate both 2-bit counters.
        begin_session();
        for (int i = 0; i < 5; i++)
            send_pat(4'(i * 3 + 1), 2'(i), (i == 4), 1'b0, 1'b1);
        wait_done(t);
        check("sat_pat_count", pat_count, 3);
        check("sat_fail_count", fail_count, 3);
        check("sat_fail", fail, 1);
        begin_session();
        check("clr_pat_count", pat_count, 0);
        check("clr_fail_count", fail_count, 0);
        check("clr_fail", fail, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
